// File: rtl/rf_rename.sv
// rf_rename: register file + rename/busy table; operands registered 1 cycle after issue, stall holds them.
// Define RF_BYPASS_EN to forward a same-cycle matching commit straight into a busy source operand.
module rf_rename #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 3,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rs2,
  input  logic [AW-1:0]    iss_rd,
  input  logic [TAG_W-1:0] iss_tag,
  input  logic             cmt_valid,
  input  logic [AW-1:0]    cmt_rd,
  input  logic [TAG_W-1:0] cmt_tag,
  input  logic [XLEN-1:0]  cmt_data,
  output logic             op_valid,
  output logic [XLEN-1:0]  op1_val,
  output logic [XLEN-1:0]  op2_val,
  output logic             op1_rdy,
  output logic             op2_rdy,
  output logic [TAG_W-1:0] op1_tag,
  output logic [TAG_W-1:0] op2_tag,
  input  logic [AW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } opnd_t;

  logic [XLEN-1:0]  regs [NREG];
  logic [NREG-1:0]  busy;
  logic [TAG_W-1:0] tag  [NREG];

  opnd_t src1, src2;

  // Sources see the mapping as it stood before this edge, so rs==rd returns the older producer.
  function automatic opnd_t read_src(input logic [AW-1:0] s);
    opnd_t o;
    o.rdy = 1'b1;
    o.tag = '0;
    o.val = '0;
    if (s != '0) begin
      if (!busy[s]) begin
        o.val = regs[s];
      end else begin
        o.rdy = 1'b0;
        o.tag = tag[s];
`ifdef RF_BYPASS_EN
        if (cmt_valid && (cmt_rd == s) && (cmt_tag == tag[s])) begin
          o.rdy = 1'b1;
          o.tag = '0;
          o.val = cmt_data;
        end
`endif
      end
    end
    return o;
  endfunction

  always_comb begin
    src1 = read_src(iss_rs1);
    src2 = read_src(iss_rs2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
      busy     <= '0;
      op_valid <= 1'b0;
      op1_val  <= '0;
      op2_val  <= '0;
      op1_rdy  <= 1'b0;
      op2_rdy  <= 1'b0;
      op1_tag  <= '0;
      op2_tag  <= '0;
      dbg_data <= '0;
    end else begin
      dbg_data <= regs[dbg_addr];

      // Data always lands; busy only clears for the youngest producer.
      if (cmt_valid && (cmt_rd != '0)) begin
        regs[cmt_rd] <= cmt_data;
        if (busy[cmt_rd] && (tag[cmt_rd] == cmt_tag))
          busy[cmt_rd] <= 1'b0;
      end

      if (!stall) begin
        if (iss_valid && !flush) begin
          op_valid <= 1'b1;
          op1_val  <= src1.val;
          op1_rdy  <= src1.rdy;
          op1_tag  <= src1.tag;
          op2_val  <= src2.val;
          op2_rdy  <= src2.rdy;
          op2_tag  <= src2.tag;
          // Placed after the commit so a same-rd rename wins over the busy clear.
          if (iss_rd != '0) begin
            busy[iss_rd] <= 1'b1;
            tag[iss_rd]  <= iss_tag;
          end
        end else begin
          op_valid <= 1'b0;
        end
      end

      if (flush)
        busy <= '0;
    end
  end

endmodule

// File: tb/tb_rf_rename.sv
// Directed bench for rf_rename: hand-computed operand/tag/debug expectations.
module tb_rf_rename;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAG_W = 3;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall, flush, iss_valid, cmt_valid;
  logic [AW-1:0]    iss_rs1, iss_rs2, iss_rd, cmt_rd, dbg_addr;
  logic [TAG_W-1:0] iss_tag, cmt_tag;
  logic [XLEN-1:0]  cmt_data;
  logic             op_valid, op1_rdy, op2_rdy;
  logic [XLEN-1:0]  op1_val, op2_val, dbg_data;
  logic [TAG_W-1:0] op1_tag, op2_tag;

  int n_chk = 0;
  int n_err = 0;

  rf_rename #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_tag(iss_tag),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
    .op_valid(op_valid), .op1_val(op1_val), .op2_val(op2_val),
    .op1_rdy(op1_rdy), .op2_rdy(op2_rdy), .op1_tag(op1_tag), .op2_tag(op2_tag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; iss_valid = 0; cmt_valid = 0;
    iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_tag = 0;
    cmt_rd = 0; cmt_tag = 0; cmt_data = 0;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic [TAG_W-1:0] t);
    iss_valid = 1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_tag = t;
  endtask

  task automatic commit(input logic [AW-1:0] rd, input logic [TAG_W-1:0] t,
                        input logic [XLEN-1:0] d);
    cmt_valid = 1; cmt_rd = rd; cmt_tag = t; cmt_data = d;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_op_valid"}, 32'(op_valid), 0);
    chk({pfx, "_op1_val"}, op1_val, 0);
    chk({pfx, "_op2_val"}, op2_val, 0);
    chk({pfx, "_op1_rdy"}, 32'(op1_rdy), 0);
    chk({pfx, "_op2_rdy"}, 32'(op2_rdy), 0);
    chk({pfx, "_op1_tag"}, 32'(op1_tag), 0);
    chk({pfx, "_op2_tag"}, 32'(op2_tag), 0);
    chk({pfx, "_dbg"}, dbg_data, 0);
  endtask

  initial begin
    idle();
    dbg_addr = 0;
    rst = 0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1;

    // First issue after reset: everything ready with zero values
    issue(5, 0, 3, 2); tick(); idle();
    chk("t1_valid", 32'(op_valid), 1);
    chk("t1_op1_rdy", 32'(op1_rdy), 1);
    chk("t1_op1_val", op1_val, 0);
    chk("t1_op2_rdy", 32'(op2_rdy), 1);
    chk("t1_op2_val", op2_val, 0);
    issue(3, 0, 0, 0); tick(); idle();
    chk("t1_r3_rdy", 32'(op1_rdy), 0);
    chk("t1_r3_tag", 32'(op1_tag), 2);

    // Rename then commit
    issue(0, 0, 3, 4); tick();
    issue(3, 0, 0, 0); tick(); idle();
    chk("t2_r3_rdy", 32'(op1_rdy), 0);
    chk("t2_r3_tag", 32'(op1_tag), 4);
    commit(3, 4, 32'hDEADBEEF); tick(); idle();
    chk("t2_idle_valid", 32'(op_valid), 0);
    chk("t2_idle_hold_tag", 32'(op1_tag), 4);
    issue(3, 0, 0, 0); tick(); idle();
    chk("t2_cmt_rdy", 32'(op1_rdy), 1);
    chk("t2_cmt_val", op1_val, 32'hDEADBEEF);
    chk("t2_cmt_tag", 32'(op1_tag), 0);

    // Stale commit writes data but leaves newer rename busy
    issue(0, 0, 7, 1); tick();
    issue(0, 0, 7, 5); tick(); idle();
    dbg_addr = 7;
    commit(7, 1, 32'h11); tick(); idle();
    chk("t3_dbg_pre", dbg_data, 0);
    tick();
    chk("t3_dbg_post", dbg_data, 32'h11);
    issue(7, 0, 0, 0); tick(); idle();
    chk("t3_stale_rdy", 32'(op1_rdy), 0);
    chk("t3_stale_tag", 32'(op1_tag), 5);

    // Same-cycle commit and read of the producing tag
    issue(0, 0, 9, 6); tick(); idle();
    commit(9, 6, 32'h55); issue(9, 9, 0, 0); tick(); idle();
`ifdef RF_BYPASS_EN
    chk("t4_byp_rdy", 32'(op1_rdy), 1);
    chk("t4_byp_val", op1_val, 32'h55);
    chk("t4_byp_tag", 32'(op1_tag), 0);
    chk("t4_byp_rdy2", 32'(op2_rdy), 1);
`else
    chk("t4_nobyp_rdy", 32'(op1_rdy), 0);
    chk("t4_nobyp_tag", 32'(op1_tag), 6);
    chk("t4_nobyp_val", op1_val, 0);
    chk("t4_nobyp_rdy2", 32'(op2_rdy), 0);
`endif
    issue(9, 0, 0, 0); tick(); idle();
    chk("t4_after_rdy", 32'(op1_rdy), 1);
    chk("t4_after_val", op1_val, 32'h55);

    // Same-cycle commit and rename of one rd: rename wins, data lands
    dbg_addr = 12;
    issue(0, 0, 12, 1); tick(); idle();
    commit(12, 1, 32'hC0); issue(0, 0, 12, 3); tick(); idle();
    tick();
    chk("t4b_dbg", dbg_data, 32'hC0);
    issue(12, 0, 0, 0); tick(); idle();
    chk("t4b_rdy", 32'(op1_rdy), 0);
    chk("t4b_tag", 32'(op1_tag), 3);

    // Flush clears renames and drops concurrent issue
    commit(4, 0, 32'h44); tick();
    commit(8, 0, 32'h88); tick(); idle();
    issue(0, 0, 4, 3); tick();
    issue(0, 0, 8, 7); tick();
    flush = 1; issue(4, 8, 10, 2); tick(); idle();
    chk("t5_flush_valid", 32'(op_valid), 0);
    issue(4, 8, 0, 0); tick(); idle();
    chk("t5_op1_rdy", 32'(op1_rdy), 1);
    chk("t5_op1_val", op1_val, 32'h44);
    chk("t5_op2_rdy", 32'(op2_rdy), 1);
    chk("t5_op2_val", op2_val, 32'h88);
    issue(10, 0, 0, 0); tick(); idle();
    chk("t5_r10_rdy", 32'(op1_rdy), 1);

    // Register 0 ignores commits
    dbg_addr = 0;
    commit(0, 0, 32'hFFFF_FFFF); tick(); idle();
    issue(0, 0, 0, 0); tick(); idle();
    chk("r0_val", op1_val, 0);
    chk("r0_dbg", dbg_data, 0);

    // Stall holds outputs while commits proceed
    issue(4, 3, 0, 0); tick(); idle();
    chk("t6_pre_op2", op2_val, 32'hDEADBEEF);
    dbg_addr = 2;
    stall = 1; issue(8, 0, 11, 1); commit(2, 0, 32'h2A);
    for (int c = 0; c < 3; c++) begin
      tick();
      cmt_valid = 0;
      chk("t6_stall_valid", 32'(op_valid), 1);
      chk("t6_stall_op1", op1_val, 32'h44);
      chk("t6_stall_op2", op2_val, 32'hDEADBEEF);
    end
    chk("t6_dbg", dbg_data, 32'h2A);
    rst = 0; tick();
    chk_all_zero("t6_rst");
    rst = 1; idle();
    issue(2, 11, 0, 0); tick(); idle();
    chk("t6_post_r2", op1_val, 0);
    chk("t6_post_r2_rdy", 32'(op1_rdy), 1);
    chk("t6_post_r11_rdy", 32'(op2_rdy), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_rename.md
# rf_rename

Parametrised architectural register file with a per-register rename/status table for the out-of-order core. It sits between decode and the reservation stations: each issued instruction reads its two source operands as either a ready value or the ROB tag that will produce it, and claims its destination with a new tag. ROB commits write data back and clear the busy state when tags match. Flush clears all pending renames after a mispredict.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count (power of two, ≥2); register 0 hardwired zero
- TAG_W, 3, ROB tag width; all 2^TAG_W values are valid tags (busy is a separate bit)
- AW, $clog2(NREG), register index width (derived, not overridable)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  hold issue-side outputs, ignore issue request
- flush  in  1  clear all busy bits
- iss_valid  in  1  issue request
- iss_rs1, iss_rs2, iss_rd  in  AW each  source/destination indices
- iss_tag  in  TAG_W  ROB tag assigned to iss_rd
- cmt_valid  in  1  commit request
- cmt_rd  in  AW  commit destination
- cmt_tag  in  TAG_W  committing ROB tag
- cmt_data  in  XLEN  commit value
- op_valid  out  1  registered operand bundle valid
- op1_val, op2_val  out  XLEN  operand value (meaningful when ready)
- op1_rdy, op2_rdy  out  1  1 = value valid, 0 = wait on tag
- op1_tag, op2_tag  out  TAG_W  producing tag when not ready
- dbg_addr  in  AW  debug read index
- dbg_data  out  XLEN  registered debug read of regs[dbg_addr]

## Operation
- State: regs[NREG], busy[NREG], tag[NREG].
- Reset (rst=0 at edge): all regs, busy, tag cleared; op_valid=0, op*_val=0, op*_rdy=0, op*_tag=0, dbg_data=0. Reset overrides commit, issue, flush.
- Commit (cmt_valid, cmt_rd≠0): regs[cmt_rd]←cmt_data always; busy[cmt_rd]←0 only if busy and tag[cmt_rd]==cmt_tag. Commits are processed regardless of stall.
- Issue (iss_valid, !stall, !flush): per source s: if s==0 or !busy[s] → val=regs[s] (pre-edge contents), rdy=1, tag=0; else rdy=0, tag=tag[s], val=0. Then if iss_rd≠0: busy[iss_rd]←1, tag[iss_rd]←iss_tag. Sources read the pre-rename mapping, so rs==rd yields the older producer.
- Same-cycle commit and issue to same rd: issue's busy/tag wins; commit data still written.
- Flush: all busy←0; regs unchanged; commit data in the same cycle still written; concurrent issue is dropped (op_valid←0, no rename).
- Register 0: never written, never busy, always reads 0.
- stall=1: op_* outputs hold previous values including op_valid.
- !iss_valid and !stall: op_valid←0, other op_* hold.

## Timing
- Issue-to-operand latency: 1 cycle (outputs registered on the edge sampling iss_valid).
- Commit visible to issue reads from the following cycle (plus same cycle with bypass, see Configuration).
- dbg_data: 1-cycle latency, reflects array after that edge's commit not applied (pre-edge contents).
- No combinational path input→output.

## Configuration
- RF_BYPASS_EN defined: when a source is busy and cmt_valid with cmt_rd==source and cmt_tag==tag[source] in the same cycle, the operand returns rdy=1, val=cmt_data, tag=0.
- Undefined: that source returns rdy=0, tag=tag[source]; the reservation station must capture the value from the commit broadcast.

## Test plan
- Reset then issue rs1=5, rs2=0, rd=3, tag=2 → next cycle op_valid=1, op1_rdy=1 val=0, op2_rdy=1 val=0; busy[3]=1 tag 2.
- Issue rd=3 tag=4, next issue rs1=3 → op1_rdy=0, op1_tag=4; commit rd=3 tag=4 data=0xDEADBEEF then issue rs1=3 → op1_rdy=1 val=0xDEADBEEF.
- Stale commit: rd=7 renamed to tag 1 then tag 5; commit rd=7 tag=1 data=0x11 → regs[7]=0x11, source 7 still reports rdy=0 tag=5.
- Same-cycle commit rd=9 tag=6 data=0x55 with issue rs1=9 (busy tag 6) → RF_BYPASS_EN: op1_rdy=1 val=0x55; without: op1_rdy=0 tag=6.
- Flush with rd 4,8 busy and concurrent issue → next cycle op_valid=0, issue rs1=4 rs2=8 returns rdy=1 with old values.
- stall=1 for 3 cycles with commit rd=2 data=0x2A → op_* unchanged throughout; dbg_addr=2 reads 0x2A; rst=0 mid-stall → all outputs 0.
